fma_result_writeback: RTL and testbench

- Registered output stage directly downstream of the FMA rounder.
- Captures the rounder's sign/exponent/mantissa and exception flags, then packs them into an IEEE-754 single-precision word.
- Carries each result through a 2-entry in-order valid/ready buffer to the FP register-file writeback.
- Maintains the RISC-V fflags accumulator (NV, DZ, OF, UF, NX), which the CSR unit can read and overwrite.

---
 rtl/fma_result_writeback_if.sv | 44 ++++
 rtl/fma_result_writeback.sv | 99 +++++++++
 tb/tb_fma_result_writeback.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fma_result_writeback_if.sv
// Bus between the FMA rounder / FP writeback / CSR unit and the
// result writeback stage. The stage itself connects through the slave modport.
interface fma_result_writeback_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_TAG  = 5
);
  // Rounder side
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic                    Sign_i;
  logic [PARM_EXP-1:0]     Exp_i;
  logic [PARM_MANT-1:0]    Mant_i;
  logic                    Invalid_i;
  logic                    Overflow_i;
  logic                    Underflow_i;
  logic                    Inexact_i;
  logic [PARM_TAG-1:0]     Tag_i;
  logic                    Flush_i;
  // Writeback side
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [PARM_EXP+PARM_MANT:0] Result_o;
  logic [PARM_TAG-1:0]     Tag_o;
  logic [4:0]              Flags_o;
  // CSR side
  logic [4:0]              Fflags_o;
  logic                    Fflags_we_i;
  logic [4:0]              Fflags_wdata_i;

  modport slave (
    input  in_valid_i, Sign_i, Exp_i, Mant_i, Invalid_i, Overflow_i,
           Underflow_i, Inexact_i, Tag_i, Flush_i, out_ready_i,
           Fflags_we_i, Fflags_wdata_i,
    output in_ready_o, out_valid_o, Result_o, Tag_o, Flags_o, Fflags_o
  );

  modport master (
    output in_valid_i, Sign_i, Exp_i, Mant_i, Invalid_i, Overflow_i,
           Underflow_i, Inexact_i, Tag_i, Flush_i, out_ready_i,
           Fflags_we_i, Fflags_wdata_i,
    input  in_ready_o, out_valid_o, Result_o, Tag_o, Flags_o, Fflags_o
  );
endinterface

// File: rtl/fma_result_writeback.sv
// FMA result writeback stage: packs rounder output into an IEEE-754 single
// word at capture, buffers up to two results in order (head + skid) and
// accumulates the RISC-V fflags as results retire.
module fma_result_writeback #(
  parameter int                   PARM_EXP      = 8,
  parameter int                   PARM_MANT     = 23,
  parameter logic [PARM_MANT-1:0] PARM_MANT_NAN = 23'h400000,
  parameter int                   PARM_TAG      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fma_result_writeback_if.slave bus
);

  localparam int W_RES = 1 + PARM_EXP + PARM_MANT;

  typedef struct packed {
    logic [W_RES-1:0]    result;
    logic [PARM_TAG-1:0] tag;
    logic [4:0]          flags;   // {NV, DZ, OF, UF, NX}
  } entry_t;

  entry_t     r_head;
  entry_t     r_skid;
  entry_t     w_new;
  logic [1:0] r_count;
  logic [4:0] r_fflags;
  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_accept;
  logic       w_retire;

  // Readiness depends only on registered occupancy, never on out_ready_i.
  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_accept    = bus.in_valid_i && w_in_ready;
  assign w_retire    = w_out_valid && bus.out_ready_i;

  // Pack the incoming rounder result; an invalid operation yields canonical qNaN.
  always_comb begin
    // NOTE: every field gets a default first so no path through this block can infer a latch.
    w_new = '0;
    if (bus.Invalid_i) begin
      w_new.result = {1'b0, {PARM_EXP{1'b1}}, PARM_MANT_NAN};
    end else begin
      w_new.result = {bus.Sign_i, bus.Exp_i, bus.Mant_i};
    end
    w_new.tag   = bus.Tag_i;
    w_new.flags = {bus.Invalid_i, 1'b0, bus.Overflow_i, bus.Underflow_i, bus.Inexact_i};
  end

  // Two-entry in-order buffer: occupancy plus head/skid data movement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the data registers are reset too, because the head drives the
      // outputs directly and they must read zero out of reset.
      r_count <= 2'd0;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (bus.Flush_i) begin
      // NOTE: non-blocking assignments keep every register update in this block
      // reading pre-edge values, so the order of statements does not matter.
      r_count <= 2'd0;
    end else begin
      unique case ({w_accept, w_retire})
        2'b10: begin
          r_count <= r_count + 2'd1;
          if (r_count == 2'd0) r_head <= w_new;
          else                 r_skid <= w_new;
        end
        2'b01: begin
          r_count <= r_count - 2'd1;
          if (r_count == 2'd2) r_head <= r_skid;
        end
        // Only reachable at count 1: the retiring head is replaced by the new entry.
        2'b11:   r_head <= w_new;
        default: ;
      endcase
    end
  end

  // fflags accumulator: CSR write and retiring flags both take effect in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fflags <= 5'd0;
    end else begin
      r_fflags <= (bus.Fflags_we_i ? bus.Fflags_wdata_i : r_fflags)
                | (w_retire ? r_head.flags : 5'd0);
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.Result_o    = r_head.result;
  assign bus.Tag_o       = r_head.tag;
  assign bus.Flags_o     = r_head.flags;
  assign bus.Fflags_o    = r_fflags;

endmodule

// File: tb/tb_fma_result_writeback.sv
// Directed bench for fma_result_writeback. Stimulus queues the hand-computed
// expected result of each accepted input; a negedge monitor pops and compares
// whenever the head retires.
module tb_fma_result_writeback;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic [4:0]  flags;
  } exp_t;

  logic clk;
  logic rst_n;

  fma_result_writeback_if #(.PARM_EXP(8), .PARM_MANT(23), .PARM_TAG(5)) bus ();

  fma_result_writeback dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops   = 0;
  exp_t sb_q[$];
  exp_t cur_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [22:0] m,
                      input logic nv, input logic of, input logic uf, input logic nx,
                      input logic [4:0] tag, input logic [31:0] exp_res,
                      input logic [4:0] exp_flags);
    bus.in_valid_i  = 1'b1;
    bus.Sign_i      = s;
    bus.Exp_i       = e;
    bus.Mant_i      = m;
    bus.Invalid_i   = nv;
    bus.Overflow_i  = of;
    bus.Underflow_i = uf;
    bus.Inexact_i   = nx;
    bus.Tag_i       = tag;
    cur_exp.res     = exp_res;
    cur_exp.tag     = tag;
    cur_exp.flags   = exp_flags;
  endtask

  // Scoreboard monitor: retire pops and compares, flush drops, accept pushes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got tag %0d expected no output", bus.Tag_o);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_pops++;
          check($sformatf("sb_result_tag%0d", e.tag), bus.Result_o, e.res);
          check($sformatf("sb_tag_tag%0d", e.tag), 32'(bus.Tag_o), 32'(e.tag));
          check($sformatf("sb_flags_tag%0d", e.tag), 32'(bus.Flags_o), 32'(e.flags));
        end
      end
      if (bus.Flush_i) sb_q.delete();
      else if (bus.in_valid_i && bus.in_ready_o) sb_q.push_back(cur_exp);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.in_valid_i     = 1'b0;
    bus.Sign_i         = 1'b0;
    bus.Exp_i          = '0;
    bus.Mant_i         = '0;
    bus.Invalid_i      = 1'b0;
    bus.Overflow_i     = 1'b0;
    bus.Underflow_i    = 1'b0;
    bus.Inexact_i      = 1'b0;
    bus.Tag_i          = '0;
    bus.Flush_i        = 1'b0;
    bus.out_ready_i    = 1'b0;
    bus.Fflags_we_i    = 1'b0;
    bus.Fflags_wdata_i = '0;
    cur_exp            = '{res: 32'h0, tag: 5'd0, flags: 5'd0};

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
    check("rst_result",    bus.Result_o,         32'h0);
    check("rst_tag",       32'(bus.Tag_o),       32'd0);
    check("rst_flags",     32'(bus.Flags_o),     32'd0);
    check("rst_fflags",    32'(bus.Fflags_o),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", 32'(bus.out_valid_o), 32'd0);

    // T1: -inf with OF+NX, one-cycle latency, fflags one cycle after retire
    bus.out_ready_i = 1'b1;
    send(1'b1, 8'hFF, 23'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'hFF800000, 5'b00101);
    step();
    bus.in_valid_i = 1'b0;
    check("t1_latency_valid", 32'(bus.out_valid_o), 32'd1);
    step();
    check("t1_fflags", 32'(bus.Fflags_o), 32'b00101);

    // T2: invalid operation packs to canonical qNaN with sign forced to 0
    send(1'b1, 8'h12, 23'h1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h7FC00000, 5'b10000);
    step();
    bus.in_valid_i = 1'b0;
    step();
    check("t2_fflags", 32'(bus.Fflags_o), 32'b10101);

    // T3: backpressure fills the buffer, tag 9 waits, in-order drain
    bus.out_ready_i = 1'b0;
    send(1'b0, 8'h80, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h40400000, 5'b00000);
    step();
    send(1'b0, 8'h81, 23'h600000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h40E00000, 5'b00000);
    step();
    check("t3_full_in_ready", 32'(bus.in_ready_o), 32'd0);
    send(1'b0, 8'h82, 23'h100000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h41100000, 5'b00000);
    step();
    check("t3_held_in_ready", 32'(bus.in_ready_o), 32'd0);
    check("t3_held_tag",      32'(bus.Tag_o),      32'd3);
    check("t3_held_result",   bus.Result_o,        32'h40400000);
    bus.out_ready_i = 1'b1;
    step();
    check("t3_recover_in_ready", 32'(bus.in_ready_o), 32'd1);
    check("t3_second_tag",       32'(bus.Tag_o),      32'd7);
    step();
    bus.in_valid_i = 1'b0;
    check("t3_third_tag", 32'(bus.Tag_o), 32'd9);
    step();
    check("t3_empty", 32'(bus.out_valid_o), 32'd0);

    // T4: CSR write and retire in the same cycle both take effect
    bus.Fflags_we_i    = 1'b1;
    bus.Fflags_wdata_i = 5'b00001;
    step();
    bus.Fflags_we_i = 1'b0;
    check("t4_csr_write", 32'(bus.Fflags_o), 32'b00001);
    send(1'b0, 8'h00, 23'h1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h00000001, 5'b00010);
    step();
    bus.in_valid_i     = 1'b0;
    bus.Fflags_we_i    = 1'b1;
    bus.Fflags_wdata_i = 5'b10000;
    step();
    bus.Fflags_we_i = 1'b0;
    check("t4_write_and_retire", 32'(bus.Fflags_o), 32'b10010);

    // T5: flush with two entries, retiring head still counts, new input dropped
    bus.out_ready_i = 1'b0;
    send(1'b0, 8'hFF, 23'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 32'h7F800000, 5'b00100);
    step();
    send(1'b0, 8'h7F, 23'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h3F800000, 5'b00001);
    step();
    check("t5_full_in_ready", 32'(bus.in_ready_o), 32'd0);
    send(1'b0, 8'h7F, 23'h1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 32'h3F800001, 5'b00000);
    bus.Flush_i     = 1'b1;
    bus.out_ready_i = 1'b1;
    step();
    bus.Flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    check("t5_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("t5_in_ready",  32'(bus.in_ready_o),  32'd1);
    check("t5_fflags",    32'(bus.Fflags_o),    32'b10110);
    step();
    step();
    check("t5_dropped", 32'(bus.out_valid_o), 32'd0);

    // T6: asynchronous reset mid-cycle with two entries buffered
    bus.out_ready_i = 1'b0;
    send(1'b1, 8'h7F, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13, 32'hBF800000, 5'b00000);
    step();
    send(1'b0, 8'h80, 23'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd14, 32'h40000000, 5'b00000);
    step();
    bus.in_valid_i = 1'b0;
    check("t6_pre_full",   32'(bus.in_ready_o), 32'd0);
    check("t6_pre_fflags", 32'(bus.Fflags_o),   32'b10110);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("t6_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("t6_in_ready",  32'(bus.in_ready_o),  32'd1);
    check("t6_fflags",    32'(bus.Fflags_o),    32'd0);
    check("t6_result",    bus.Result_o,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_post_out_valid", 32'(bus.out_valid_o), 32'd0);

    // Every issued-and-kept result must have been delivered exactly once.
    check("sb_pops",     32'(n_pops),      32'd7);
    check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
